// File: rtl/maq_min_seg.sv
// MM:SS BCD time base: counts seconds/minutes and emits a one-cycle carry to the hour counter.
// Define MIN_SEG_PRESCALER_EN for the internal CLK_HZ prescaler; otherwise seconds advance on tick_in.
module maq_min_seg #(
`ifdef MIN_SEG_PRESCALER_EN
  parameter int CLK_HZ = 50_000_000,
`endif
  parameter int unsigned AJUSTE_CARRY = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       ajuste_min,
  input  logic       zera_seg,
`ifndef MIN_SEG_PRESCALER_EN
  input  logic       tick_in,
`endif
  output logic [3:0] bcd_s_lsd,
  output logic [2:0] bcd_s_msd,
  output logic [3:0] bcd_m_lsd,
  output logic [2:0] bcd_m_msd,
  output logic       incrementa_hora,
  output logic       tick_1hz
);

  // Packed {msd[2:0], lsd[3:0]}; out-of-range digits behave as terminal so the count self-heals.
  function automatic logic [7:0] bcd_inc(input logic [6:0] v);
    logic [3:0] lsd;
    logic [2:0] msd;
    lsd = v[3:0];
    msd = v[6:4];
    if (lsd >= 4'd9) begin
      if (msd >= 3'd5) bcd_inc = {1'b1, 7'd0};
      else             bcd_inc = {1'b0, msd + 3'd1, 4'd0};
    end else begin
      bcd_inc = {1'b0, msd, lsd + 4'd1};
    end
  endfunction

  logic [6:0] sec_q, sec_d;
  logic [6:0] min_q, min_d;
  logic       ajuste_q;
  logic       inc_q, inc_d;
  logic       tick_q, tick_d;
  logic       tick;
  logic [7:0] sec_step, min_one, min_two;
  logic       mc, adj, wrap, carry;

`ifdef MIN_SEG_PRESCALER_EN
  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] TC = CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick   = en && (cnt_q == TC);
    tick_d = tick && !zera_seg;
    cnt_d  = cnt_q;
    if (zera_seg)  cnt_d = '0;
    else if (tick) cnt_d = '0;
    else if (en)   cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  always_comb begin
    tick   = en && tick_in;
    tick_d = tick_in;
  end
`endif

  always_comb begin
    sec_step = bcd_inc(sec_q);
    min_one  = bcd_inc(min_q);
    min_two  = bcd_inc(min_one[6:0]);
    adj      = ajuste_min && !ajuste_q;
    mc       = tick && !zera_seg && sec_step[7];

    sec_d = sec_q;
    if (zera_seg)  sec_d = '0;
    else if (tick) sec_d = sec_step[6:0];

    // Carry and adjust in the same cycle advance the minutes by two.
    min_d = min_q;
    wrap  = 1'b0;
    if (mc && adj) begin
      min_d = min_two[6:0];
      wrap  = min_one[7] | min_two[7];
    end else if (mc || adj) begin
      min_d = min_one[6:0];
      wrap  = min_one[7];
    end

    carry = wrap && (mc || (AJUSTE_CARRY != 0));
    inc_d = carry && !inc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sec_q    <= '0;
      min_q    <= '0;
      ajuste_q <= 1'b0;
      inc_q    <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      sec_q    <= sec_d;
      min_q    <= min_d;
      ajuste_q <= ajuste_min;
      inc_q    <= inc_d;
      tick_q   <= tick_d;
    end
  end

  assign bcd_s_lsd       = sec_q[3:0];
  assign bcd_s_msd       = sec_q[6:4];
  assign bcd_m_lsd       = min_q[3:0];
  assign bcd_m_msd       = min_q[6:4];
  assign incrementa_hora = inc_q;
  assign tick_1hz        = tick_q;

endmodule

// File: tb/tb_maq_min_seg.sv
// Directed bench for maq_min_seg; works with or without MIN_SEG_PRESCALER_EN (prescaler uses CLK_HZ=4).
module tb_maq_min_seg;

  logic       clk = 1'b0;
  logic       rst, en, ajuste_min, zera_seg;
`ifndef MIN_SEG_PRESCALER_EN
  logic       tick_in;
`endif
  logic [3:0] bcd_s_lsd, bcd_m_lsd;
  logic [2:0] bcd_s_msd, bcd_m_msd;
  logic       incrementa_hora, tick_1hz;
  logic [13:0] time_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  maq_min_seg #(
`ifdef MIN_SEG_PRESCALER_EN
    .CLK_HZ(4),
`endif
    .AJUSTE_CARRY(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .ajuste_min(ajuste_min),
    .zera_seg(zera_seg),
`ifndef MIN_SEG_PRESCALER_EN
    .tick_in(tick_in),
`endif
    .bcd_s_lsd(bcd_s_lsd),
    .bcd_s_msd(bcd_s_msd),
    .bcd_m_lsd(bcd_m_lsd),
    .bcd_m_msd(bcd_m_msd),
    .incrementa_hora(incrementa_hora),
    .tick_1hz(tick_1hz)
  );

  assign time_o = {bcd_m_msd, bcd_m_lsd, bcd_s_msd, bcd_s_lsd};

  function automatic logic [13:0] bcd(input int mm, input int ss);
    bcd = {3'(mm / 10), 4'(mm % 10), 3'(ss / 10), 4'(ss % 10)};
  endfunction

  // Advance n edges, returning 1 time unit after the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    en = 1'b0;
    ajuste_min = 1'b0;
    zera_seg = 1'b0;
`ifndef MIN_SEG_PRESCALER_EN
    tick_in = 1'b0;
`endif
  endtask

  // One second: returns just after the edge on which the seconds advance.
  task automatic sec_tick();
`ifdef MIN_SEG_PRESCALER_EN
    en = 1'b1;
    cyc(4);
    en = 1'b0;
`else
    en = 1'b1;
    tick_in = 1'b1;
    cyc(1);
    tick_in = 1'b0;
    en = 1'b0;
`endif
  endtask

  task automatic set_time(input int mm, input int ss);
    idle_inputs();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    for (int i = 0; i < mm; i++) begin
      ajuste_min = 1'b1;
      cyc(1);
      ajuste_min = 1'b0;
      cyc(1);
    end
    for (int i = 0; i < ss; i++) sec_tick();
  endtask

  task automatic test_reset();
    set_time(12, 34);
    en = 1'b1;
    ajuste_min = 1'b1;
    rst = 1'b1;
    cyc(1);
    checks++;
    if (time_o !== bcd(0, 0)) begin
      failures++; $display("FAIL reset_mid time got %h exp %h", time_o, bcd(0, 0));
    end
    cyc(1);
    checks++;
    if (time_o !== bcd(0, 0)) begin
      failures++; $display("FAIL reset_hold time got %h exp %h", time_o, bcd(0, 0));
    end
    checks++;
    if (incrementa_hora !== 1'b0) begin
      failures++; $display("FAIL reset_inc got %b exp 0", incrementa_hora);
    end
    checks++;
    if (tick_1hz !== 1'b0) begin
      failures++; $display("FAIL reset_tick got %b exp 0", tick_1hz);
    end
    rst = 1'b0;
    idle_inputs();
    cyc(1);
  endtask

`ifdef MIN_SEG_PRESCALER_EN
  task automatic test_prescaler();
    set_time(0, 0);
    en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cyc(1);
      checks++;
      if (tick_1hz !== ((k % 4) == 0)) begin
        failures++; $display("FAIL presc_tick k=%0d got %b exp %b", k, tick_1hz, (k % 4) == 0);
      end
      checks++;
      if (time_o !== bcd(0, k / 4)) begin
        failures++; $display("FAIL presc_sec k=%0d got %h exp %h", k, time_o, bcd(0, k / 4));
      end
    end
    en = 1'b0;
  endtask
`else
  task automatic test_tick_in();
    set_time(0, 0);
    tick_in = 1'b1;
    cyc(1);
    checks++;
    if (tick_1hz !== 1'b1 || time_o !== bcd(0, 0)) begin
      failures++; $display("FAIL tickin_gated tick=%b time=%h exp tick=1 time=%h", tick_1hz, time_o, bcd(0, 0));
    end
    tick_in = 1'b0;
    en = 1'b1;
    cyc(1);
    checks++;
    if (tick_1hz !== 1'b0 || time_o !== bcd(0, 0)) begin
      failures++; $display("FAIL tickin_idle tick=%b time=%h exp tick=0 time=%h", tick_1hz, time_o, bcd(0, 0));
    end
    tick_in = 1'b1;
    cyc(1);
    checks++;
    if (tick_1hz !== 1'b1 || time_o !== bcd(0, 1)) begin
      failures++; $display("FAIL tickin_run tick=%b time=%h exp tick=1 time=%h", tick_1hz, time_o, bcd(0, 1));
    end
    idle_inputs();
    cyc(1);
  endtask
`endif

  task automatic test_freeze();
    set_time(0, 7);
    cyc(10);
    checks++;
    if (time_o !== bcd(0, 7) || tick_1hz !== 1'b0) begin
      failures++; $display("FAIL freeze time=%h tick=%b exp time=%h tick=0", time_o, tick_1hz, bcd(0, 7));
    end
    zera_seg = 1'b1;
    cyc(1);
    zera_seg = 1'b0;
    checks++;
    if (time_o !== bcd(0, 0)) begin
      failures++; $display("FAIL zera_no_en got %h exp %h", time_o, bcd(0, 0));
    end
  endtask

  task automatic test_hour_wrap();
    set_time(59, 58);
    sec_tick();
    checks++;
    if (time_o !== bcd(59, 59) || incrementa_hora !== 1'b0) begin
      failures++; $display("FAIL wrap_5959 time=%h inc=%b exp time=%h inc=0", time_o, incrementa_hora, bcd(59, 59));
    end
    sec_tick();
    checks++;
    if (time_o !== bcd(0, 0)) begin
      failures++; $display("FAIL wrap_0000 got %h exp %h", time_o, bcd(0, 0));
    end
    checks++;
    if (incrementa_hora !== 1'b1) begin
      failures++; $display("FAIL wrap_inc_on got %b exp 1", incrementa_hora);
    end
    cyc(1);
    checks++;
    if (incrementa_hora !== 1'b0) begin
      failures++; $display("FAIL wrap_inc_off got %b exp 0", incrementa_hora);
    end
    cyc(2);
    checks++;
    if (incrementa_hora !== 1'b0 || time_o !== bcd(0, 0)) begin
      failures++; $display("FAIL wrap_after inc=%b time=%h exp inc=0 time=%h", incrementa_hora, time_o, bcd(0, 0));
    end
  endtask

  task automatic test_ajuste();
    set_time(12, 30);
    ajuste_min = 1'b1;
    cyc(1);
    checks++;
    if (time_o !== bcd(13, 30)) begin
      failures++; $display("FAIL adj_first got %h exp %h", time_o, bcd(13, 30));
    end
    cyc(9);
    checks++;
    if (time_o !== bcd(13, 30) || incrementa_hora !== 1'b0) begin
      failures++; $display("FAIL adj_held time=%h inc=%b exp time=%h inc=0", time_o, incrementa_hora, bcd(13, 30));
    end
    ajuste_min = 1'b0;
    cyc(1);
    ajuste_min = 1'b1;
    cyc(1);
    ajuste_min = 1'b0;
    checks++;
    if (time_o !== bcd(14, 30)) begin
      failures++; $display("FAIL adj_repress got %h exp %h", time_o, bcd(14, 30));
    end
    cyc(1);
  endtask

  task automatic test_ajuste_wrap();
    set_time(59, 10);
    ajuste_min = 1'b1;
    cyc(1);
    ajuste_min = 1'b0;
    checks++;
    if (time_o !== bcd(0, 10) || incrementa_hora !== 1'b1) begin
      failures++; $display("FAIL adjwrap time=%h inc=%b exp time=%h inc=1", time_o, incrementa_hora, bcd(0, 10));
    end
    cyc(1);
    checks++;
    if (incrementa_hora !== 1'b0) begin
      failures++; $display("FAIL adjwrap_off got %b exp 0", incrementa_hora);
    end
  endtask

  task automatic test_zera();
    set_time(5, 59);
`ifdef MIN_SEG_PRESCALER_EN
    en = 1'b1;
    cyc(3);
    zera_seg = 1'b1;
    cyc(1);
`else
    en = 1'b1;
    tick_in = 1'b1;
    zera_seg = 1'b1;
    cyc(1);
    tick_in = 1'b0;
`endif
    zera_seg = 1'b0;
    en = 1'b0;
    checks++;
    if (time_o !== bcd(5, 0) || incrementa_hora !== 1'b0) begin
      failures++; $display("FAIL zera_tick time=%h inc=%b exp time=%h inc=0", time_o, incrementa_hora, bcd(5, 0));
    end
    cyc(1);
    checks++;
    if (time_o !== bcd(5, 0) || incrementa_hora !== 1'b0) begin
      failures++; $display("FAIL zera_after time=%h inc=%b exp time=%h inc=0", time_o, incrementa_hora, bcd(5, 0));
    end
`ifdef MIN_SEG_PRESCALER_EN
    en = 1'b1;
    cyc(2);
    zera_seg = 1'b1;
    cyc(1);
    zera_seg = 1'b0;
    cyc(3);
    checks++;
    if (time_o !== bcd(5, 0)) begin
      failures++; $display("FAIL zera_presc_early got %h exp %h", time_o, bcd(5, 0));
    end
    cyc(1);
    en = 1'b0;
`else
    sec_tick();
`endif
    checks++;
    if (time_o !== bcd(5, 1)) begin
      failures++; $display("FAIL zera_resume got %h exp %h", time_o, bcd(5, 1));
    end
  endtask

  task automatic test_double();
    set_time(59, 59);
`ifdef MIN_SEG_PRESCALER_EN
    en = 1'b1;
    cyc(3);
    ajuste_min = 1'b1;
    cyc(1);
`else
    en = 1'b1;
    tick_in = 1'b1;
    ajuste_min = 1'b1;
    cyc(1);
    tick_in = 1'b0;
`endif
    en = 1'b0;
    ajuste_min = 1'b0;
    checks++;
    if (time_o !== bcd(1, 0)) begin
      failures++; $display("FAIL double_time got %h exp %h", time_o, bcd(1, 0));
    end
    checks++;
    if (incrementa_hora !== 1'b1) begin
      failures++; $display("FAIL double_inc_on got %b exp 1", incrementa_hora);
    end
    cyc(1);
    checks++;
    if (incrementa_hora !== 1'b0 || time_o !== bcd(1, 0)) begin
      failures++; $display("FAIL double_after inc=%b time=%h exp inc=0 time=%h", incrementa_hora, time_o, bcd(1, 0));
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    cyc(2);
    rst = 1'b0;
    test_reset();
`ifdef MIN_SEG_PRESCALER_EN
    test_prescaler();
`else
    test_tick_in();
`endif
    test_freeze();
    test_hour_wrap();
    test_ajuste();
    test_ajuste_wrap();
    test_zera();
    test_double();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
